alu_seq: RTL

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential 8-bit ALU with multi-cycle MUL and bit-serial shifts
//
// Purpose: executes one operation per START, writes its result to a register
// file through WRITE/INADDRESS/RESULT. FWD/ADD/AND/OR take one EXEC cycle,
// MUL takes eight (shift-and-add), shifts take max(min(DATA2,8),1).
//
// Ports:
//   CLK        rising-edge clock
//   RESET      synchronous, active-high reset
//   START      request one operation (accepted in IDLE or DONE)
//   OPCODE     000 FWD, 001 ADD, 010 AND, 011 OR, 100 MUL, 101 SLL, 110 SRL, 111 SRA
//   DATA1      operand 1
//   DATA2      operand 2 / shift amount
//   DEST       destination register index
//   BUSY       high while executing
//   DONE       one-cycle completion pulse
//   RESULT     registered result
//   ZERO       RESULT == 0, registered with RESULT
//   WRITE      register-file write strobe (same cycle as DONE)
//   INADDRESS  register-file write index (latched DEST)
module alu_seq #(
  parameter int DW = 8
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          START,
  input  logic [2:0]    OPCODE,
  input  logic [DW-1:0] DATA1,
  input  logic [DW-1:0] DATA2,
  input  logic [2:0]    DEST,
  output logic          BUSY,
  output logic          DONE,
  output logic [DW-1:0] RESULT,
  output logic          ZERO,
  output logic          WRITE,
  output logic [2:0]    INADDRESS
);

  localparam int CW = $clog2(DW + 1);
  localparam logic [DW-1:0] SH_CAP  = DW'(DW);
  localparam logic [CW-1:0] CNT_CAP = CW'(DW);

  localparam logic [2:0] OP_FWD = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [DW-1:0] a_q, a_d;       // operand 1; shifted in place for MUL and shifts
  logic [DW-1:0] b_q, b_d;       // operand 2; multiplier bits consumed LSB-first
  logic [DW-1:0] acc_q, acc_d;   // MUL partial product
  logic [CW-1:0] cnt_q, cnt_d;   // EXEC steps remaining (0 only for shift-by-0)
  logic [2:0]    dest_q, dest_d;
  logic [DW-1:0] result_q, result_d;
  logic          zero_q, zero_d;
  logic [2:0]    addr_q, addr_d;
  logic [DW-1:0] sh_val;
  logic [DW-1:0] fin;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      dest_q   <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      dest_q   <= dest_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      addr_q   <= addr_d;
    end
  end

  // One-bit shift step of the working operand.
  always_comb begin
    sh_val = a_q;
    case (op_q)
      OP_SLL:  sh_val = {a_q[DW-2:0], 1'b0};
      OP_SRL:  sh_val = {1'b0, a_q[DW-1:1]};
      default: sh_val = {a_q[DW-1], a_q[DW-1:1]};
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    dest_d   = dest_q;
    result_d = result_q;
    zero_d   = zero_q;
    addr_d   = addr_q;
    fin      = '0;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (START) begin
          state_d = S_EXEC;
          op_d    = OPCODE;
          a_d     = DATA1;
          b_d     = DATA2;
          acc_d   = '0;
          dest_d  = DEST;
          if (OPCODE == OP_MUL)
            cnt_d = CNT_CAP;
          else if (OPCODE[2])
            cnt_d = (DATA2 >= SH_CAP) ? CNT_CAP : DATA2[CW-1:0];
          else
            cnt_d = CW'(1);
        end
      end
      S_EXEC: begin
        case (op_q)
          OP_FWD: fin = b_q;
          OP_ADD: fin = a_q + b_q;
          OP_AND: fin = a_q & b_q;
          OP_OR:  fin = a_q | b_q;
          OP_MUL: begin
            acc_d = acc_q + (b_q[0] ? a_q : '0);
            a_d   = {a_q[DW-2:0], 1'b0};
            b_d   = {1'b0, b_q[DW-1:1]};
            fin   = acc_d;
          end
          default: begin
            // A zero shift count still spends one cycle but leaves DATA1 as is.
            if (cnt_q != '0)
              a_d = sh_val;
            fin = a_d;
          end
        endcase
        if (cnt_q != '0)
          cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CW'(1)) begin
          state_d  = S_DONE;
          result_d = fin;
          zero_d   = (fin == '0);
          addr_d   = dest_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign BUSY      = (state_q == S_EXEC);
  assign DONE      = (state_q == S_DONE);
  assign WRITE     = (state_q == S_DONE);
  assign RESULT    = result_q;
  assign ZERO      = zero_q;
  assign INADDRESS = addr_q;

endmodule
